dbus_axi_bridge: RTL and testbench

//  Data-side bus bridge directly downstream of the MEM stage's memory interface. Converts MEM's

---
 rtl/dbus_axi_bridge_pkg.sv | 50 +++++
 rtl/dbus_axi_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_dbus_axi_bridge.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_axi_bridge_pkg.sv
// Shared types and constants for the data-bus to AXI4 bridge.
package dbus_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned RESP_W = 2;

  localparam logic [1:0]        BURST_INCR  = 2'b01;
  localparam logic [SIZE_W-1:0] SIZE_B      = 3'd0;
  localparam logic [SIZE_W-1:0] SIZE_H      = 3'd1;
  localparam logic [SIZE_W-1:0] SIZE_W_WORD = 3'd2;
  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    WR_AW_W,
    WR_B,
    DONE,
    DRAIN
  } state_e;

  // Request captured from MEM at acceptance; drives the AXI payload.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wmask;
    logic [SIZE_W-1:0] size;
    logic              we;
  } req_t;

  // AXI size code from MEM's access-size flags (word wins over halfword).
  function automatic logic [SIZE_W-1:0] size_of(input logic halfword, input logic word);
    if (word)          return SIZE_W_WORD;
    else if (halfword) return SIZE_H;
    else               return SIZE_B;
  endfunction

  // SLVERR and DECERR both count as a failed access.
  function automatic logic resp_is_err(input logic [RESP_W-1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/dbus_axi_bridge.sv
// MEM-stage level request to single-beat AXI4 read/write bridge, one
// transaction outstanding. Optional DBUS_RESP_ERR_EN adds bus_err reporting.
module dbus_axi_bridge
  import dbus_axi_bridge_pkg::*;
#(
  parameter int unsigned    ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = 4'h1
) (
  input  logic              clk,
  input  logic              reset,
  // MEM side
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [STRB_W-1:0] wmask,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_halfword,
  input  logic              mem_word,
  input  logic              is_fire,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              write_finish,
`ifdef DBUS_RESP_ERR_EN
  output logic              bus_err,
`endif
  // AXI AR
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [SIZE_W-1:0] arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  // AXI R
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [RESP_W-1:0] rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // AXI AW
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [LEN_W-1:0]  awlen,
  output logic [SIZE_W-1:0] awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  // AXI W
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // AXI B
  input  logic [ID_W-1:0]   bid,
  input  logic [RESP_W-1:0] bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_e state_q, state_d;
  req_t   req_q, req_d;
  logic   aw_sent_q, aw_sent_d;
  logic   w_sent_q, w_sent_d;
  logic   flush_q, flush_d;
  logic [DATA_W-1:0] rdata_d;
  logic   arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
  logic   rdata_valid_d, write_finish_d;
`ifdef DBUS_RESP_ERR_EN
  logic   err_q, err_d;
  logic   bus_err_d;
  logic   unused_ok;
  assign unused_ok = ^{rid, rlast, bid};
`else
  logic   unused_ok;
  assign unused_ok = ^{rid, rlast, bid, rresp, bresp};
`endif

  // Fixed single-beat INCR attributes; payload comes from the latched request.
  assign arid    = AXI_ID;
  assign arlen   = '0;
  assign arburst = BURST_INCR;
  assign araddr  = req_q.addr;
  assign arsize  = req_q.size;
  assign awid    = AXI_ID;
  assign awlen   = '0;
  assign awburst = BURST_INCR;
  assign awaddr  = req_q.addr;
  assign awsize  = req_q.size;
  assign wdata_o = req_q.wdata;
  assign wstrb   = req_q.wmask;
  assign wlast   = 1'b1;

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    aw_sent_d = aw_sent_q;
    w_sent_d  = w_sent_q;
    flush_d   = flush_q;
    rdata_d   = rdata;
`ifdef DBUS_RESP_ERR_EN
    err_d     = err_q;
`endif

    // Dropping en mid-transaction means MEM flushed; finish on AXI, then drain.
    if (state_q inside {RD_AR, RD_R, WR_AW_W, WR_B}) flush_d = flush_q | ~en;

    unique case (state_q)
      IDLE: begin
        aw_sent_d = 1'b0;
        w_sent_d  = 1'b0;
        flush_d   = 1'b0;
`ifdef DBUS_RESP_ERR_EN
        err_d     = 1'b0;
`endif
        if (en) begin
          req_d.addr  = addr;
          req_d.wdata = wdata;
          req_d.wmask = wmask;
          req_d.size  = size_of(mem_halfword, mem_word);
          req_d.we    = we;
          state_d     = we ? WR_AW_W : RD_AR;
        end
      end
      RD_AR: if (arvalid && arready) state_d = RD_R;
      RD_R: begin
        if (rvalid && rready) begin
          rdata_d = rdata_i;
`ifdef DBUS_RESP_ERR_EN
          err_d   = resp_is_err(rresp);
`endif
          state_d = flush_d ? DRAIN : DONE;
        end
      end
      WR_AW_W: begin
        aw_sent_d = aw_sent_q | (awvalid & awready);
        w_sent_d  = w_sent_q | (wvalid & wready);
        if (aw_sent_d && w_sent_d) state_d = WR_B;
      end
      WR_B: begin
        if (bvalid && bready) begin
`ifdef DBUS_RESP_ERR_EN
          err_d   = resp_is_err(bresp);
`endif
          state_d = flush_d ? DRAIN : DONE;
        end
      end
      DONE:    if (is_fire || !en) state_d = IDLE;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != DONE) rdata_d = '0;

    arvalid_d      = (state_d == RD_AR);
    rready_d       = (state_d == RD_R);
    awvalid_d      = (state_d == WR_AW_W) && !aw_sent_d;
    wvalid_d       = (state_d == WR_AW_W) && !w_sent_d;
    bready_d       = (state_d == WR_B);
    rdata_valid_d  = (state_d == DONE) && !req_d.we;
    write_finish_d = (state_d == DONE) && req_d.we;
`ifdef DBUS_RESP_ERR_EN
    bus_err_d      = (state_d == DONE) && err_d;
`endif
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      aw_sent_q    <= 1'b0;
      w_sent_q     <= 1'b0;
      flush_q      <= 1'b0;
      rdata        <= '0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
      rdata_valid  <= 1'b0;
      write_finish <= 1'b0;
`ifdef DBUS_RESP_ERR_EN
      err_q        <= 1'b0;
      bus_err      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      aw_sent_q    <= aw_sent_d;
      w_sent_q     <= w_sent_d;
      flush_q      <= flush_d;
      rdata        <= rdata_d;
      arvalid      <= arvalid_d;
      rready       <= rready_d;
      awvalid      <= awvalid_d;
      wvalid       <= wvalid_d;
      bready       <= bready_d;
      rdata_valid  <= rdata_valid_d;
      write_finish <= write_finish_d;
`ifdef DBUS_RESP_ERR_EN
      err_q        <= err_d;
      bus_err      <= bus_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_dbus_axi_bridge.sv
// Directed self-checking bench for dbus_axi_bridge; the AXI slave is driven
// cycle by cycle from the stimulus sequence.
module tb_dbus_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, we, mem_halfword, mem_word, is_fire;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wmask;
  logic        rdata_valid, write_finish;
`ifdef DBUS_RESP_ERR_EN
  logic        bus_err;
`endif
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, awaddr, rdata_i, wdata_o;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;
  int ar_hs = 0;
  int aw_hs = 0;
  int w_hs  = 0;

  always #5 clk = ~clk;

  dbus_axi_bridge dut (
    .clk(clk), .reset(reset),
    .en(en), .we(we), .addr(addr), .wmask(wmask), .wdata(wdata),
    .mem_halfword(mem_halfword), .mem_word(mem_word), .is_fire(is_fire),
    .rdata(rdata), .rdata_valid(rdata_valid), .write_finish(write_finish),
`ifdef DBUS_RESP_ERR_EN
    .bus_err(bus_err),
`endif
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata_i(rdata_i), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata_o(wdata_o), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Handshake counters, used to catch duplicated address/data beats.
  always @(posedge clk) begin
    if (arvalid && arready) ar_hs++;
    if (awvalid && awready) aw_hs++;
    if (wvalid && wready)   w_hs++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then settled and inputs may be changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_load(input logic [31:0] a);
    en = 1'b1; we = 1'b0; addr = a; mem_word = 1'b1; mem_halfword = 1'b0;
  endtask

  initial begin
    int ar0;
    reset = 1'b0;
    en = 0; we = 0; addr = 0; wmask = 0; wdata = 0; mem_halfword = 0; mem_word = 0; is_fire = 0;
    arready = 0; rid = 4'h1; rdata_i = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 4'h1; bresp = 0; bvalid = 0;
    step(); step();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_write_finish", write_finish, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk) reset = 1'b1;
    step();

    // 1: word load, arready one cycle late
    mem_load(32'h1c00_0010);
    step();
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 32'h1c00_0010);
    chk("t1_arsize", arsize, 2);
    chk("t1_arlen", arlen, 0);
    chk("t1_arburst", arburst, 1);
    chk("t1_arid", arid, 1);
    step();
    chk("t1_arvalid_hold", arvalid, 1);
    arready = 1;
    step();
    chk("t1_arvalid_drop", arvalid, 0);
    chk("t1_rready", rready, 1);
    arready = 0; rvalid = 1; rdata_i = 32'hdead_beef;
    step();
    rvalid = 0;
    chk("t1_rdata_valid", rdata_valid, 1);
    chk("t1_rdata", rdata, 32'hdead_beef);
    chk("t1_rready_drop", rready, 0);
    step();
    chk("t1_rdata_valid_hold", rdata_valid, 1);
    is_fire = 1;
    step();
    is_fire = 0; en = 0;
    chk("t1_rdata_valid_clr", rdata_valid, 0);
    chk("t1_rdata_clr", rdata, 0);
    step();

    // 2: byte store, awready two cycles ahead of wready
    aw_hs = 0; w_hs = 0;
    en = 1; we = 1; addr = 32'h8000_0003; wmask = 4'b1000; wdata = 32'hab00_0000;
    mem_word = 0; mem_halfword = 0;
    step();
    chk("t2_awvalid", awvalid, 1);
    chk("t2_wvalid", wvalid, 1);
    chk("t2_awaddr", awaddr, 32'h8000_0003);
    chk("t2_awsize", awsize, 0);
    chk("t2_wstrb", wstrb, 4'b1000);
    chk("t2_wdata_o", wdata_o, 32'hab00_0000);
    chk("t2_wlast", wlast, 1);
    addr = 32'h0; wdata = 32'h0; wmask = 4'h0;
    awready = 1;
    step();
    awready = 0;
    chk("t2_awvalid_drop", awvalid, 0);
    chk("t2_wvalid_hold", wvalid, 1);
    chk("t2_bready_early", bready, 0);
    chk("t2_awaddr_latched", awaddr, 32'h8000_0003);
    step();
    chk("t2_awvalid_low", awvalid, 0);
    wready = 1;
    step();
    wready = 0;
    chk("t2_wvalid_drop", wvalid, 0);
    chk("t2_bready", bready, 1);
    step();
    chk("t2_bready_hold", bready, 1);
    chk("t2_wf_early", write_finish, 0);
    bvalid = 1; bresp = 2'b10;
    step();
    bvalid = 0; bresp = 0;
    chk("t2_write_finish", write_finish, 1);
    chk("t2_bready_drop", bready, 0);
`ifdef DBUS_RESP_ERR_EN
    chk("t2_bus_err", bus_err, 1);
`endif
    chk("t2_aw_count", aw_hs, 1);
    chk("t2_w_count", w_hs, 1);
    is_fire = 1;
    step();
    is_fire = 0; en = 0; we = 0;
    chk("t2_wf_clr", write_finish, 0);
    step();

    // 3: back-to-back loads with a zero-wait slave
    ar0 = ar_hs;
    arready = 1;
    mem_load(32'h0000_0100);
    step();
    chk("t3_arvalid1", arvalid, 1);
    step();
    chk("t3_rready1", rready, 1);
    rvalid = 1; rdata_i = 32'h1111_1111;
    step();
    rvalid = 0;
    chk("t3_latency_rv", rdata_valid, 1);
    chk("t3_rdata1", rdata, 32'h1111_1111);
    is_fire = 1; addr = 32'h0000_0200;
    step();
    is_fire = 0;
    chk("t3_no_ar_in_fire", arvalid, 0);
    chk("t3_rv_clr", rdata_valid, 0);
    step();
    chk("t3_arvalid2", arvalid, 1);
    chk("t3_araddr2", araddr, 32'h0000_0200);
    step();
    chk("t3_arvalid2_drop", arvalid, 0);
    chk("t3_ar_count", ar_hs - ar0, 2);
    arready = 0; rvalid = 1; rdata_i = 32'h2222_2222;
    step();
    rvalid = 0;
    chk("t3_rdata2", rdata, 32'h2222_2222);
    is_fire = 1;
    step();
    is_fire = 0; en = 0;
    step();

    // 4: flush during RD_R
    mem_load(32'h0000_0300);
    step();
    arready = 1;
    step();
    arready = 0; en = 0;
    chk("t4_rready", rready, 1);
    step();
    chk("t4_rready_hold", rready, 1);
    chk("t4_no_rv", rdata_valid, 0);
    rvalid = 1; rdata_i = 32'h3333_3333;
    step();
    rvalid = 0;
    chk("t4_drain_rv", rdata_valid, 0);
    chk("t4_drain_rready", rready, 0);
    chk("t4_drain_rdata", rdata, 0);
    step();
    chk("t4_idle_rv", rdata_valid, 0);
    chk("t4_idle_arvalid", arvalid, 0);

    // 5: stall in DONE for five cycles
    ar0 = ar_hs;
    arready = 1;
    mem_load(32'h0000_0400);
    step();
    step();
    arready = 0; rvalid = 1; rdata_i = 32'hcafe_f00d;
    step();
    rvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_rv_stable", rdata_valid, 1);
      chk("t5_rdata_stable", rdata, 32'hcafe_f00d);
      chk("t5_no_new_ar", arvalid, 0);
      step();
    end
    chk("t5_ar_count", ar_hs - ar0, 1);
    is_fire = 1;
    step();
    is_fire = 0; en = 0;
    chk("t5_rv_clr", rdata_valid, 0);
    step();

    // 6: reset asserted in WR_B, then a fresh load
    en = 1; we = 1; addr = 32'h0000_0500; wmask = 4'hf; wdata = 32'h5555_5555; mem_word = 1;
    step();
    awready = 1; wready = 1;
    step();
    awready = 0; wready = 0;
    chk("t6_bready", bready, 1);
    en = 0; we = 0;
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_bready", bready, 0);
    chk("t6_rst_awvalid", awvalid, 0);
    chk("t6_rst_wvalid", wvalid, 0);
    chk("t6_rst_wf", write_finish, 0);
    @(negedge clk) reset = 1'b1;
    step();
    arready = 1;
    mem_load(32'h0000_0600);
    step();
    chk("t6_arvalid", arvalid, 1);
    chk("t6_araddr", araddr, 32'h0000_0600);
    step();
    arready = 0; rvalid = 1; rdata_i = 32'h6666_6666;
    step();
    rvalid = 0;
    chk("t6_rv", rdata_valid, 1);
    chk("t6_rdata", rdata, 32'h6666_6666);
    is_fire = 1;
    step();
    is_fire = 0; en = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
